// File: rtl/timer_pkg.sv
// Shared kitchen-timer definitions: entry FSM states, cursor codes, digit limits.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] CUR_MIN0 = 2'd3;
    localparam logic [1:0] CUR_MIN1 = 2'd2;
    localparam logic [1:0] CUR_SEC0 = 2'd1;
    localparam logic [1:0] CUR_SEC1 = 2'd0;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    // Tens positions (MM tens, SS tens) stop at 5, ones positions at 9.
    function automatic logic [3:0] digit_max(input logic [1:0] cur);
        return (cur == CUR_MIN0 || cur == CUR_SEC0) ? TENS_MAX : ONES_MAX;
    endfunction

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] max);
        return (d == 4'd0 || d > max) ? max : d - 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stability counter,
// one-cycle pulse on the accepted rising edge.
module btn_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize, accept a new level after it has persisted, then edge-detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/time_entry.sv
// Front-panel MM:SS entry: four debounced buttons edit BCD digits, a commit
// converts them to binary minutes/seconds and strobes load for one cycle.
module time_entry
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_set,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [5:0] min_set,
    output logic [5:0] sec_set,
    output logic       load,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [1:0] cursor,
    output logic       editing
);

    logic set_ev;
    logic sel_ev;
    logic inc_ev;
    logic dec_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk(clk), .reset(reset), .btn(btn_set), .press(set_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk(clk), .reset(reset), .btn(btn_sel), .press(sel_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .press(inc_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .press(dec_ev));

    state_t state_q;
    state_t state_d;
    logic   enter_edit;
    logic   do_sel;
    logic   do_inc;
    logic   do_dec;

    logic [3:0] sel_digit;
    logic [3:0] sel_max;
    logic [3:0] new_digit;
    logic [5:0] min_bin;
    logic [5:0] sec_bin;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and one-hot edit actions; enable loss beats set, set > sel > inc > dec.
    always_comb begin
        state_d    = state_q;
        enter_edit = 1'b0;
        do_sel     = 1'b0;
        do_inc     = 1'b0;
        do_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (set_ev && enable) begin
                    state_d    = ST_EDIT;
                    enter_edit = 1'b1;
                end
            end
            ST_EDIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (set_ev) begin
                    state_d = ST_COMMIT;
                end else if (sel_ev) begin
                    do_sel = 1'b1;
                end else if (inc_ev) begin
                    do_inc = 1'b1;
                end else if (dec_ev) begin
                    do_dec = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Selected digit, its stepped value, and BCD->binary (x*10 = x<<3 + x<<1).
    always_comb begin
        case (cursor)
            CUR_MIN0: sel_digit = min0;
            CUR_MIN1: sel_digit = min1;
            CUR_SEC0: sel_digit = sec0;
            default:  sel_digit = sec1;
        endcase
        sel_max   = digit_max(cursor);
        new_digit = do_inc ? digit_inc(sel_digit, sel_max)
                           : digit_dec(sel_digit, sel_max);
        min_bin   = ({2'b00, min0} << 3) + ({2'b00, min0} << 1) + {2'b00, min1};
        sec_bin   = ({2'b00, sec0} << 3) + ({2'b00, sec0} << 1) + {2'b00, sec1};
    end

    // Registered outputs: digits, cursor, status flags and committed values.
    always_ff @(posedge clk) begin
        if (reset) begin
            min0    <= 4'd0;
            min1    <= 4'd0;
            sec0    <= 4'd0;
            sec1    <= 4'd0;
            cursor  <= CUR_MIN0;
            editing <= 1'b0;
            load    <= 1'b0;
            min_set <= 6'd0;
            sec_set <= 6'd0;
        end else begin
            editing <= (state_d == ST_EDIT);
            load    <= (state_d == ST_COMMIT);
            if (enter_edit) begin
                cursor <= CUR_MIN0;
            end else if (do_sel) begin
                cursor <= cursor - 2'd1;
            end
            if (do_inc || do_dec) begin
                case (cursor)
                    CUR_MIN0: min0 <= new_digit;
                    CUR_MIN1: min1 <= new_digit;
                    CUR_SEC0: sec0 <= new_digit;
                    default:  sec1 <= new_digit;
                endcase
            end
            if (state_d == ST_COMMIT) begin
                min_set <= min_bin;
                sec_set <= sec_bin;
            end
        end
    end

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry with a short debounce window.
module tb_time_entry;
    import timer_pkg::*;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       btn_set, btn_sel, btn_inc, btn_dec;
    logic [5:0] min_set, sec_set;
    logic       load;
    logic [3:0] min0, min1, sec0, sec1;
    logic [1:0] cursor;
    logic       editing;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;
    int last_min = -1;
    int last_sec = -1;

    time_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_set(btn_set), .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .min_set(min_set), .sec_set(sec_set), .load(load),
        .min0(min0), .min1(min1), .sec0(sec0), .sec1(sec1),
        .cursor(cursor), .editing(editing)
    );

    always #5 clk = ~clk;

    // Count load-high cycles and capture the committed values alongside.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            last_min = int'(min_set);
            last_sec = int'(sec_set);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bits: [3]=set [2]=sel [1]=inc [0]=dec
    task automatic press(input logic [3:0] mask);
        {btn_set, btn_sel, btn_inc, btn_dec} = mask;
        tick(10);
        {btn_set, btn_sel, btn_inc, btn_dec} = 4'b0000;
        tick(12);
    endtask

    task automatic press_n(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    function automatic int digits();
        return int'({min0, min1, sec0, sec1});
    endfunction

    localparam logic [3:0] SET = 4'b1000, SEL = 4'b0100, INC = 4'b0010, DEC = 4'b0001;

    initial begin
        reset = 1'b1; enable = 1'b1;
        {btn_set, btn_sel, btn_inc, btn_dec} = 4'b0000;
        tick(3);
        reset = 1'b0;
        tick(1);

        chk("rst_min_set", min_set, 0);
        chk("rst_sec_set", sec_set, 0);
        chk("rst_load", load, 0);
        chk("rst_cursor", cursor, 3);
        chk("rst_editing", editing, 0);
        chk("rst_digits", digits(), 0);

        press(SET);
        chk("edit_editing", editing, 1);
        chk("edit_cursor", cursor, 3);

        // 3-cycle glitch must not register
        btn_inc = 1'b1; tick(3); btn_inc = 1'b0; tick(12);
        chk("glitch_digits", digits(), 0);

        // raw->press is 7 edges, digit visible after the 8th
        btn_inc = 1'b1;
        tick(7);
        chk("lat_before", min0, 0);
        tick(1);
        chk("lat_after", min0, 1);
        tick(2); btn_inc = 1'b0; tick(12);

        press(INC);
        press(SEL);
        press_n(INC, 5);
        press(SEL);
        press_n(INC, 3);
        press(SEL);
        press(DEC);
        chk("entry_digits", digits(), 16'h2539);
        chk("entry_cursor", cursor, 0);
        chk("entry_noload", load_cnt, 0);
        press(SET);
        chk("entry_loads", load_cnt, 1);
        chk("entry_min", last_min, 25);
        chk("entry_sec", last_sec, 39);
        chk("entry_editing", editing, 0);
        chk("entry_hold_min", min_set, 25);
        chk("entry_hold_sec", sec_set, 39);

        // Wrap
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        press(SET);
        press_n(INC, 6);
        chk("wrap_tens_inc", digits(), 0);
        press_n(SEL, 3);
        chk("wrap_cursor", cursor, 0);
        press(DEC);
        chk("wrap_ones_dec", sec1, 9);
        press(SEL);
        chk("wrap_cursor_3", cursor, 3);
        press(SEL);
        press_n(INC, 5);
        press(SEL);
        press(DEC);
        chk("wrap_digits", digits(), 16'h0559);
        press(SET);
        chk("wrap_loads", load_cnt, 2);
        chk("wrap_min", last_min, 5);
        chk("wrap_sec", last_sec, 59);

        // Abort
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        press(SET);
        press(INC);
        press(SET);
        chk("pre_abort_loads", load_cnt, 3);
        chk("pre_abort_min", min_set, 10);
        press(SET);
        chk("abort_in_edit", editing, 1);
        enable = 1'b0;
        tick(3);
        chk("abort_editing", editing, 0);
        chk("abort_loads", load_cnt, 3);
        chk("abort_min", min_set, 10);
        chk("abort_digits", digits(), 16'h1000);
        enable = 1'b1;
        press(INC);
        chk("abort_idle_ignores", digits(), 16'h1000);

        // Priority
        press(SET);
        press(SEL | INC);
        chk("prio_sel_cursor", cursor, 2);
        chk("prio_sel_digits", digits(), 16'h1000);
        press(SET | INC);
        chk("prio_set_loads", load_cnt, 4);
        chk("prio_set_digits", digits(), 16'h1000);
        chk("prio_set_editing", editing, 0);
        chk("prio_set_min", min_set, 10);

        // Reset mid-edit
        press(SET);
        press(INC);
        chk("mid_pre_digits", digits(), 16'h2000);
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        chk("mid_digits", digits(), 0);
        chk("mid_editing", editing, 0);
        chk("mid_loads", load_cnt, 4);
        chk("mid_min_set", min_set, 0);
        enable = 1'b0;
        press(SET);
        chk("disabled_set", editing, 0);
        chk("disabled_loads", load_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_entry.md
# time_entry

Front-panel time-entry block for the kitchen timer: the input-side counterpart of the display integrator. It debounces four push-buttons, lets the user edit four BCD digits (MM:SS) one at a time, and converts the result to 6-bit binary minutes/seconds for the timer. A completed entry is delivered with a one-cycle load pulse. Live digits and cursor position are exported so the display path can show and blink the digit being edited.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of cycles a synchronized button level must hold stable before it is accepted (10 ms at 100 MHz).
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  entry permitted; high only while the timer is stopped
- `btn_set`  in  1  raw button, asynchronous: start edit / commit
- `btn_sel`  in  1  raw button: move cursor
- `btn_inc`  in  1  raw button: increment selected digit
- `btn_dec`  in  1  raw button: decrement selected digit
- `min_set`  out  6  committed minutes, binary 0–59
- `sec_set`  out  6  committed seconds, binary 0–59
- `load`  out  1  one-cycle strobe; `min_set`/`sec_set` are valid this cycle
- `min0`, `min1`, `sec0`, `sec1`  out  4 each  live BCD digits:
  - `min0` = minutes tens, `min1` = minutes ones
  - `sec0` = seconds tens, `sec1` = seconds ones
- `cursor`  out  2  selected digit: 3 = `min0`, 2 = `min1`, 1 = `sec0`, 0 = `sec1`
- `editing`  out  1  high while in EDIT

## Operation
- **Button conditioning (each button):**
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press event is a one-cycle pulse on the debounced rising edge. Releases generate nothing.
- **States:** IDLE, EDIT, COMMIT.
- **IDLE:**
  - `set` event with `enable`=1 → EDIT, `cursor` ← 3.
  - All other events are ignored.
- **EDIT:**
  - `sel` event: cursor 3→2→1→0→3.
  - `inc` event on the selected digit:
    - tens digits wrap 5→0;
    - ones digits wrap 9→0.
  - `dec` event on the selected digit:
    - tens digits wrap 0→5;
    - ones digits wrap 0→9.
  - `set` event → COMMIT.
  - `enable` low → IDLE. This is an abort: digits are kept, `load` is not asserted, `min_set`/`sec_set` are unchanged.
- **COMMIT** (exactly one cycle):
  - `min_set` ← `min0`·10 + `min1`, `sec_set` ← `sec0`·10 + `sec1` (6-bit results, maximum 59).
  - `load` = 1.
  - Next state is IDLE.
- **Simultaneous events in the same cycle:** priority is `set` > `sel` > `inc` > `dec`. Lower-priority events are discarded, not queued.
- **Abort vs `set`:** if `enable` falls in the same cycle as a `set` event in EDIT, the abort wins.
- **Digit range:** digits never leave their legal range (tens 0–5, ones 0–9). Value 00:00 is committable; the timer decides what it means.

## Timing
- **Reset values:**
  - all digits 0, `min_set` = 0, `sec_set` = 0;
  - `load` = 0, `cursor` = 3, `editing` = 0;
  - state IDLE, debounced levels 0, debounce counters 0.
- **Reset mid-edit:** the edit is discarded and no `load` is produced.
- **Button latency:** from raw edge to press event is 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- **Event latency:** a digit or cursor change is visible on the outputs 1 cycle after the press event.
- **`set` in EDIT:**
  - COMMIT occupies the next cycle;
  - `load` is high in that cycle, with `min_set`/`sec_set` already updated in the same cycle;
  - `editing` drops in that same cycle.
- **Hold:** `min_set`/`sec_set` are held until the next COMMIT.
- **Registered outputs:** all outputs come from registers; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `timer_pkg`:**
  - state enum (IDLE/EDIT/COMMIT);
  - cursor constants (CUR_MIN0=3 … CUR_SEC1=0);
  - `TENS_MAX`=5, `ONES_MAX`=9.
- **Sub-module `btn_debounce`:**
  - contains the synchronizer, counter and rising-edge pulse, parameterized by `DEBOUNCE_CYCLES`;
  - instantiated four times.
- **BCD→binary:** a ×10 implemented as (x<<3)+(x<<1), placed inline in COMMIT.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** after reset, outputs are 0, `cursor`=3, `editing`=0. A 3-cycle glitch on `btn_inc` produces no event and the digits stay 0.
- **Full entry:** with `enable`=1, apply:
  - `set`;
  - `inc`×2, `sel`, `inc`×5, `sel`, `inc`×3, `sel`, `dec`×1;
  - `set`.
  - Required: digits read 2,5,3,9 and there is exactly one `load` pulse with `min_set`=25, `sec_set`=39.
- **Wrap:** with cursor=3, apply `inc`×6 → `min0`=0. With cursor=0 at 0, apply `dec` → `sec1`=9. After commit of 05:59, `min_set`=5 and `sec_set`=59.
- **Abort:** in EDIT with digits 1,0,0,0, drop `enable`. Required: state returns to IDLE, `editing`=0, no `load`, `min_set` keeps its prior value, digits stay 1,0,0,0.
- **Priority:**
  - `sel` and `inc` events in the same cycle → only the cursor moves.
  - `set` and `inc` in the same cycle → COMMIT, and the digit is unchanged.
- **Reset mid-edit:** assert `reset` during EDIT. Required: digits 0, state IDLE, no `load`. A `set` press while `enable`=0 leaves `editing`=0.
